// File: rtl/value_stack_pkg.sv
// ============================================================================
//  Module      : value_stack_pkg
//  Description : Shared op codes, trap codes and FSM state type for the
//                WebAssembly operand stack.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package value_stack_pkg;

    // Stack operation codes (shared with the CPU decoder)
    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_SELECT  = 3'd3;
    localparam logic [2:0] OP_DUP     = 3'd4;
    localparam logic [2:0] OP_SWAP    = 3'd5;
    localparam logic [2:0] OP_CLEAR   = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    // Trap codes (shared with the CPU trap logic)
    localparam logic [3:0] TRAP_NONE      = 4'd0;
    localparam logic [3:0] TRAP_UNDERFLOW = 4'd1;
    localparam logic [3:0] TRAP_OVERFLOW  = 4'd2;
    localparam logic [3:0] TRAP_BAD_OP    = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RELOAD  = 3'd1,
        ST_SEL_A   = 3'd2,
        ST_SEL_B   = 3'd3,
        ST_SWAP_WR = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/value_stack_ram.sv
// ============================================================================
//  Module      : value_stack_ram
//  Description : Storage for the entries below TOS. One write port, one
//                synchronous read port (data valid the cycle after the
//                request). Contents are not reset.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module value_stack_ram #(
    parameter int WIDTH   = 64,
    parameter int ENTRIES = 15,
    parameter int AW      = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [ENTRIES];

    // Write port and registered read port; the controller never reads and
    // writes the same address in one cycle, so no bypass is needed.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/value_stack.sv
// ============================================================================
//  Module      : value_stack
//  Description : WebAssembly operand stack. TOS lives in a register, lower
//                entries in value_stack_ram. Supports PUSH/POP/DUP/SWAP/CLEAR
//                and a three-cycle SELECT, with a sticky trap code.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module value_stack
    import value_stack_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] result,
    output logic             result_empty,
    output logic [CW-1:0]    count,
    output logic [3:0]       trap
);

    localparam int          AW   = CW - 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t             state, state_n;
    logic [WIDTH-1:0]   tos, tos_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic               sel_c, sel_c_n;
    logic [WIDTH-1:0]   sel_val2, sel_val2_n;
    logic [3:0]         trap_r, trap_n;

    logic               ram_we, ram_re;
    logic [AW-1:0]      ram_waddr, ram_raddr;
    logic [WIDTH-1:0]   ram_wdata, ram_rdata;

    // Low count bits are enough to form RAM addresses: modular arithmetic
    // gives the right index whenever the address is actually used.
    logic [AW-1:0]      cnt_lo, addr_m1, addr_m2, addr_m3;
    logic               accept;

    assign cnt_lo  = cnt[AW-1:0];
    assign addr_m1 = cnt_lo - AW'(1);
    assign addr_m2 = cnt_lo - AW'(2);
    assign addr_m3 = cnt_lo - AW'(3);

    assign op_ready     = (state == ST_IDLE) && (trap_r == TRAP_NONE);
    assign accept       = op_valid && op_ready;
    assign result       = (cnt != '0) ? tos : '0;
    assign result_empty = (cnt == '0);
    assign count        = cnt;
    assign trap         = trap_r;

    value_stack_ram #(
        .WIDTH   (WIDTH),
        .ENTRIES (DEPTH - 1),
        .AW      (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            tos      <= '0;
            cnt      <= '0;
            sel_c    <= 1'b0;
            sel_val2 <= '0;
            trap_r   <= TRAP_NONE;
        end else begin
            state    <= state_n;
            tos      <= tos_n;
            cnt      <= cnt_n;
            sel_c    <= sel_c_n;
            sel_val2 <= sel_val2_n;
            trap_r   <= trap_n;
        end
    end

    // Op decode, bounds checks, next-state and RAM port control
    always_comb begin
        state_n    = state;
        tos_n      = tos;
        cnt_n      = cnt;
        sel_c_n    = sel_c;
        sel_val2_n = sel_val2;
        trap_n     = trap_r;
        ram_we     = 1'b0;
        ram_waddr  = addr_m1;
        ram_wdata  = tos;
        ram_re     = 1'b0;
        ram_raddr  = addr_m2;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        OP_PUSH: begin
                            if (cnt == FULL) begin
                                trap_n = TRAP_OVERFLOW;
                            end else begin
                                ram_we = (cnt != '0);
                                tos_n  = push_data;
                                cnt_n  = cnt + CW'(1);
                            end
                        end
                        OP_POP: begin
                            if (cnt == '0) begin
                                trap_n = TRAP_UNDERFLOW;
                            end else if (cnt == CW'(1)) begin
                                cnt_n = '0;
                                tos_n = '0;
                            end else begin
                                ram_re  = 1'b1;
                                cnt_n   = cnt - CW'(1);
                                state_n = ST_RELOAD;
                            end
                        end
                        OP_SELECT: begin
                            if (cnt < CW'(3)) begin
                                trap_n = TRAP_UNDERFLOW;
                            end else begin
                                sel_c_n = (tos[31:0] != 32'd0);
                                ram_re  = 1'b1;
                                state_n = ST_SEL_A;
                            end
                        end
                        OP_DUP: begin
                            if (cnt == '0) begin
                                trap_n = TRAP_UNDERFLOW;
                            end else if (cnt == FULL) begin
                                trap_n = TRAP_OVERFLOW;
                            end else begin
                                ram_we = 1'b1;
                                cnt_n  = cnt + CW'(1);
                            end
                        end
                        OP_SWAP: begin
                            if (cnt < CW'(2)) begin
                                trap_n = TRAP_UNDERFLOW;
                            end else begin
                                ram_re  = 1'b1;
                                state_n = ST_SWAP_WR;
                            end
                        end
                        OP_CLEAR: begin
                            cnt_n = '0;
                        end
                        OP_ILLEGAL: begin
                            trap_n = TRAP_BAD_OP;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_RELOAD: begin
                tos_n   = ram_rdata;
                state_n = ST_IDLE;
            end
            ST_SEL_A: begin
                sel_val2_n = ram_rdata;
                ram_re     = 1'b1;
                ram_raddr  = addr_m3;
                state_n    = ST_SEL_B;
            end
            ST_SEL_B: begin
                tos_n   = sel_c ? ram_rdata : sel_val2;
                cnt_n   = cnt - CW'(2);
                state_n = ST_IDLE;
            end
            ST_SWAP_WR: begin
                ram_we    = 1'b1;
                ram_waddr = addr_m2;
                tos_n     = ram_rdata;
                state_n   = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_value_stack.sv
// ============================================================================
//  Module      : tb_value_stack
//  Description : Directed self-checking bench for value_stack (WIDTH=64,
//                DEPTH=4).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_value_stack;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             op_valid = 1'b0;
    logic             op_ready;
    logic [2:0]       op = 3'd0;
    logic [WIDTH-1:0] push_data = '0;
    logic [WIDTH-1:0] result;
    logic             result_empty;
    logic [CW-1:0]    count;
    logic [3:0]       trap;

    int checks = 0;
    int errors = 0;

    value_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op           (op),
        .push_data    (push_data),
        .result       (result),
        .result_empty (result_empty),
        .count        (count),
        .trap         (trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Waits (bounded) for op_ready, then presents one op for a single accept edge
    task automatic issue(input logic [2:0] o, input logic [63:0] d);
        int n;
        n = 0;
        while (!op_ready && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!op_ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout observed=0 expected=1");
        end
        op_valid  = 1'b1;
        op        = o;
        push_data = d;
        @(posedge clk);
        #1;
        op_valid  = 1'b0;
        op        = 3'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_count", 64'(count), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_empty", 64'(result_empty), 64'd1);
        check("rst_ready", 64'(op_ready), 64'd1);
        check("rst_trap", 64'(trap), 64'd0);

        // SELECT with zero condition picks val2 (=2)
        issue(3'd1, 64'd1);
        issue(3'd1, 64'd2);
        issue(3'd1, 64'd0);
        check("sel0_count_pre", 64'(count), 64'd3);
        issue(3'd3, 64'd0);
        check("sel0_ready_c1", 64'(op_ready), 64'd0);
        check("sel0_count_c1", 64'(count), 64'd3);
        step();
        check("sel0_ready_c2", 64'(op_ready), 64'd0);
        step();
        check("sel0_ready_c3", 64'(op_ready), 64'd1);
        check("sel0_result", result, 64'd2);
        check("sel0_count", 64'(count), 64'd1);
        check("sel0_empty", 64'(result_empty), 64'd0);

        // SELECT with non-zero condition picks val1 (=7)
        do_reset();
        issue(3'd1, 64'd7);
        issue(3'd1, 64'd9);
        issue(3'd1, 64'd5);
        issue(3'd3, 64'd0);
        check("sel1_ready_c1", 64'(op_ready), 64'd0);
        step();
        check("sel1_ready_c2", 64'(op_ready), 64'd0);
        step();
        check("sel1_ready_c3", 64'(op_ready), 64'd1);
        check("sel1_result", result, 64'd7);
        check("sel1_count", 64'(count), 64'd1);

        // Overflow on the fifth PUSH
        do_reset();
        issue(3'd1, 64'd1);
        issue(3'd1, 64'd2);
        issue(3'd1, 64'd3);
        issue(3'd1, 64'd4);
        check("full_count", 64'(count), 64'd4);
        check("full_result", result, 64'd4);
        issue(3'd1, 64'd5);
        check("ovf_trap", 64'(trap), 64'd2);
        check("ovf_count", 64'(count), 64'd4);
        check("ovf_result", result, 64'd4);
        check("ovf_ready", 64'(op_ready), 64'd0);
        step();
        step();
        check("ovf_ready_sticky", 64'(op_ready), 64'd0);
        check("ovf_trap_sticky", 64'(trap), 64'd2);

        // SWAP exchanges TOS and below; POP then reloads the swapped-down 8
        do_reset();
        issue(3'd1, 64'd3);
        issue(3'd1, 64'd8);
        issue(3'd5, 64'd0);
        check("swap_ready_c1", 64'(op_ready), 64'd0);
        step();
        check("swap_ready_c2", 64'(op_ready), 64'd1);
        check("swap_result", result, 64'd3);
        check("swap_count", 64'(count), 64'd2);
        issue(3'd2, 64'd0);
        check("pop_ready_c1", 64'(op_ready), 64'd0);
        check("pop_count", 64'(count), 64'd1);
        step();
        check("pop_ready_c2", 64'(op_ready), 64'd1);
        check("pop_result", result, 64'd8);
        issue(3'd2, 64'd0);
        check("pop_last_ready", 64'(op_ready), 64'd1);
        check("pop_last_empty", 64'(result_empty), 64'd1);
        check("pop_last_result", result, 64'd0);
        check("pop_last_trap", 64'(trap), 64'd0);

        // Underflow on POP of an empty stack
        do_reset();
        issue(3'd2, 64'd0);
        check("uf_pop_trap", 64'(trap), 64'd1);
        check("uf_pop_ready", 64'(op_ready), 64'd0);

        // Underflow on SWAP with a single entry
        do_reset();
        issue(3'd1, 64'd1);
        issue(3'd5, 64'd0);
        check("uf_swap_trap", 64'(trap), 64'd1);
        check("uf_swap_count", 64'(count), 64'd1);

        // Illegal op code
        do_reset();
        issue(3'd7, 64'd0);
        check("badop_trap", 64'(trap), 64'd3);
        check("badop_ready", 64'(op_ready), 64'd0);

        // Asynchronous reset in the middle of SELECT
        do_reset();
        issue(3'd1, 64'd1);
        issue(3'd1, 64'd2);
        issue(3'd1, 64'd3);
        issue(3'd3, 64'd0);
        reset = 1'b1;
        #2;
        check("midsel_count", 64'(count), 64'd0);
        check("midsel_trap", 64'(trap), 64'd0);
        check("midsel_ready", 64'(op_ready), 64'd1);
        check("midsel_result", result, 64'd0);
        reset = 1'b0;
        step();
        check("midsel_ready_after", 64'(op_ready), 64'd1);
        check("midsel_count_after", 64'(count), 64'd0);

        // DUP twice then CLEAR; a POP between confirms DUP stored the copy
        do_reset();
        issue(3'd1, 64'hA);
        issue(3'd4, 64'd0);
        issue(3'd4, 64'd0);
        check("dup_count", 64'(count), 64'd3);
        check("dup_result", result, 64'hA);
        issue(3'd2, 64'd0);
        step();
        check("dup_pop_result", result, 64'hA);
        check("dup_pop_count", 64'(count), 64'd2);
        issue(3'd6, 64'd0);
        check("clr_count", 64'(count), 64'd0);
        check("clr_result", result, 64'd0);
        check("clr_empty", 64'(result_empty), 64'd1);
        check("clr_ready", 64'(op_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
